// File: rtl/riscv_cpu_pkg.sv
// Shared core types and widths used by the writeback stage.
package riscv_cpu_pkg;

  localparam int unsigned ADDR_WIDTH = 5;
  localparam int unsigned DATA_WIDTH = 32;

  typedef enum logic [2:0] {
    LB  = 3'd0,
    LH  = 3'd1,
    LW  = 3'd2,
    LBU = 3'd4,
    LHU = 3'd5
  } wb_load_e;

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } wb_state_e;

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/halfword of a load response and sign/zero-extends it.
module load_align
  import riscv_cpu_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] rdata_i,
  input  logic [1:0]            offset_i,
  input  wb_load_e              type_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[7:0];
    unique case (offset_i)
      2'd0: byte_sel = rdata_i[7:0];
      2'd1: byte_sel = rdata_i[15:8];
      2'd2: byte_sel = rdata_i[23:16];
      2'd3: byte_sel = rdata_i[31:24];
      default: byte_sel = rdata_i[7:0];
    endcase
    // Halfword loads ignore the low offset bit.
    half_sel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    data_o = rdata_i;
    case (type_i)
      LB:      data_o = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
      LBU:     data_o = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
      LH:      data_o = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
      LHU:     data_o = {{(DATA_WIDTH-16){1'b0}}, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: retires instructions, completes loads and drives the register-file write port.
module writeback_stage
  import riscv_cpu_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  input  logic                  rd_we_i,
  input  logic [DATA_WIDTH-1:0] result_i,
  input  logic                  is_load_i,
  input  logic [2:0]            load_type_i,
  input  logic [1:0]            byte_offset_i,
  input  logic                  data_rvalid_i,
  input  logic [DATA_WIDTH-1:0] data_rdata_i,
  output logic [ADDR_WIDTH-1:0] waddr_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic                  we_o,
  output logic                  retire_o,
  output logic                  pending_o,
  output logic [ADDR_WIDTH-1:0] pending_rd_o,
  output logic [CNT_WIDTH-1:0]  instret_o
);

  wb_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] ld_rd_q, ld_rd_d;
  logic                  ld_we_q, ld_we_d;
  wb_load_e              ld_type_q, ld_type_d;
  logic [1:0]            ld_off_q, ld_off_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  we_q, we_d;
  logic                  retire_q, retire_d;
  logic [CNT_WIDTH-1:0]  instret_q, instret_d;
  logic [DATA_WIDTH-1:0] ext_data;

  load_align u_load_align (
    .rdata_i  (data_rdata_i),
    .offset_i (ld_off_q),
    .type_i   (ld_type_q),
    .data_o   (ext_data)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      ld_rd_q   <= '0;
      ld_we_q   <= 1'b0;
      ld_type_q <= LW;
      ld_off_q  <= '0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      retire_q  <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      ld_rd_q   <= ld_rd_d;
      ld_we_q   <= ld_we_d;
      ld_type_q <= ld_type_d;
      ld_off_q  <= ld_off_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      retire_q  <= retire_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ld_rd_d   = ld_rd_q;
    ld_we_d   = ld_we_q;
    ld_type_d = ld_type_q;
    ld_off_d  = ld_off_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    we_d      = 1'b0;
    retire_d  = 1'b0;
    // Counter trails the retire pulse by one cycle.
    instret_d = instret_q + CNT_WIDTH'(retire_q);

    unique case (state_q)
      IDLE: begin
        if (valid_i) begin
          if (is_load_i) begin
            ld_rd_d   = rd_addr_i;
            ld_we_d   = rd_we_i;
            ld_type_d = wb_load_e'(load_type_i);
            ld_off_d  = byte_offset_i;
            state_d   = WAIT_LOAD;
          end else begin
            retire_d = 1'b1;
            waddr_d  = rd_addr_i;
            wdata_d  = result_i;
            we_d     = rd_we_i && (rd_addr_i != '0);
          end
        end
      end
      WAIT_LOAD: begin
        if (data_rvalid_i) begin
          state_d  = IDLE;
          retire_d = 1'b1;
          waddr_d  = ld_rd_q;
          wdata_d  = ext_data;
          we_d     = ld_we_q && (ld_rd_q != '0);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ready_o      = (state_q == IDLE);
  assign pending_o    = (state_q == WAIT_LOAD);
  assign pending_rd_o = ld_rd_q;
  assign waddr_o      = waddr_q;
  assign wdata_o      = wdata_q;
  assign we_o         = we_q;
  assign retire_o     = retire_q;
  assign instret_o    = instret_q;

endmodule
